// File: rtl/odd_signal.sv
// Registered 4-input odd-parity detector with popcount output.
// Optional running parity accumulator is compiled in with ODD_SIGNAL_ACC_EN.
module odd_signal #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  output logic             y,
  output logic [2:0]       ones_cnt,
  output logic             out_valid
`ifdef ODD_SIGNAL_ACC_EN
  ,
  input  logic             acc_clr,
  output logic             acc_y,
  output logic [CNT_W-1:0] odd_cnt
`endif
);

  logic       y_n;
  logic [2:0] ones_cnt_n;

  // Next-sample parity and popcount; only consumed when in_valid is high.
  always_comb begin
    y_n        = a ^ b ^ c ^ d;
    ones_cnt_n = 3'(a) + 3'(b) + 3'(c) + 3'(d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y         <= 1'b0;
      ones_cnt  <= 3'd0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y        <= y_n;
        ones_cnt <= ones_cnt_n;
      end
    end
  end

`ifdef ODD_SIGNAL_ACC_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // A clear on the same edge as a sample restarts the stream at that sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_y   <= 1'b0;
      odd_cnt <= '0;
    end else if (acc_clr) begin
      acc_y   <= in_valid & y_n;
      odd_cnt <= CNT_W'(in_valid & y_n);
    end else if (in_valid) begin
      acc_y <= acc_y ^ y_n;
      if (odd_cnt != CNT_MAX) begin
        odd_cnt <= odd_cnt + CNT_W'(y_n);
      end
    end
  end
`endif

endmodule

// File: tb/tb_odd_signal.sv
// Self-checking bench for odd_signal: vector table, hand sequences and a
// randomized run against a count-based reference model.
module tb_odd_signal;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       a, b, c, d;
  logic       y;
  logic [2:0] ones_cnt;
  logic       out_valid;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model state
  int unsigned m_y, m_cnt, m_ov;

`ifdef ODD_SIGNAL_ACC_EN
  logic       acc_clr;
  logic       acc_y, acc_y2;
  logic [7:0] odd_cnt;
  logic [1:0] odd_cnt2;
  logic       y2, ov2;
  logic [2:0] cnt2;
  int unsigned m_acc, m_odd, m_odd2;
`endif

  always #5 clk = ~clk;

  odd_signal dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .d(d),
    .y(y), .ones_cnt(ones_cnt), .out_valid(out_valid)
`ifdef ODD_SIGNAL_ACC_EN
    , .acc_clr(acc_clr), .acc_y(acc_y), .odd_cnt(odd_cnt)
`endif
  );

`ifdef ODD_SIGNAL_ACC_EN
  odd_signal #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .d(d),
    .y(y2), .ones_cnt(cnt2), .out_valid(ov2),
    .acc_clr(acc_clr), .acc_y(acc_y2), .odd_cnt(odd_cnt2)
  );
`endif

  typedef struct {
    logic       v;
    logic [3:0] nib;
    logic       ey;
    logic [2:0] ecnt;
    logic       eov;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_y = 0; m_cnt = 0; m_ov = 0;
`ifdef ODD_SIGNAL_ACC_EN
    m_acc = 0; m_odd = 0; m_odd2 = 0;
`endif
  endtask

  // Apply one cycle of stimulus at the falling edge, update model at the
  // rising edge, then settle just past it.
  task automatic drive(input logic v, input logic [3:0] nib, input logic clr);
    int unsigned pop, par;
    @(negedge clk);
    in_valid = v;
    {d, c, b, a} = nib;
`ifdef ODD_SIGNAL_ACC_EN
    acc_clr = clr;
`endif
    pop = nib[0] + nib[1] + nib[2] + nib[3];
    par = pop % 2;
    @(posedge clk);
    m_ov = v;
    if (v) begin
      m_y = par; m_cnt = pop;
    end
`ifdef ODD_SIGNAL_ACC_EN
    if (clr) begin
      m_acc = v ? par : 0; m_odd = v ? par : 0; m_odd2 = m_odd;
    end else if (v) begin
      m_acc  = m_acc ^ par;
      m_odd  = (m_odd + par > 255) ? 255 : m_odd + par;
      m_odd2 = (m_odd2 + par > 3) ? 3 : m_odd2 + par;
    end
`else
    if (clr) m_ov = m_ov;
`endif
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".y"}, y, m_y);
    chk({tag, ".ones_cnt"}, ones_cnt, m_cnt);
    chk({tag, ".out_valid"}, out_valid, m_ov);
`ifdef ODD_SIGNAL_ACC_EN
    chk({tag, ".acc_y"}, acc_y, m_acc);
    chk({tag, ".odd_cnt"}, odd_cnt, m_odd);
    chk({tag, ".acc_y2"}, acc_y2, m_acc);
    chk({tag, ".odd_cnt2"}, odd_cnt2, m_odd2);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
`ifdef ODD_SIGNAL_ACC_EN
    acc_clr = 1'b0;
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0]  ylist;
    logic [15:0] yexp;
    rst_n = 1'b0; in_valid = 1'b0; {d, c, b, a} = 4'b0;
`ifdef ODD_SIGNAL_ACC_EN
    acc_clr = 1'b0;
`endif
    model_reset();
    #1;
    chk("reset.y", y, 0);
    chk("reset.ones_cnt", ones_cnt, 0);
    chk("reset.out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive sweep: y sequence 0,1,1,0,1,0,0,1,1,0,0,1,0,1,1,0 (index 0 is LSB here)
    yexp = 16'b0110_1001_1001_0110;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] n;
      n = 4'(i);
      vecs.push_back('{1'b1, n, yexp[i], 3'($countones(n)), 1'b1});
    end
    // Hold: accept 0001 then three idle cycles with inputs 1111
    vecs.push_back('{1'b1, 4'b0001, 1'b1, 3'd1, 1'b1});
    for (int i = 0; i < 3; i++) vecs.push_back('{1'b0, 4'b1111, 1'b1, 3'd1, 1'b0});

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].nib, 1'b0);
      chk($sformatf("vec%0d.y", i), y, vecs[i].ey);
      chk($sformatf("vec%0d.ones_cnt", i), ones_cnt, vecs[i].ecnt);
      chk($sformatf("vec%0d.out_valid", i), out_valid, vecs[i].eov);
    end

    // Asynchronous reset mid-stream
    drive(1'b1, 4'b0111, 1'b0);
    chk("pre_rst.y", y, 1);
    chk("pre_rst.ones_cnt", ones_cnt, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.y", y, 0);
    chk("async_rst.ones_cnt", ones_cnt, 0);
    chk("async_rst.out_valid", out_valid, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;

`ifdef ODD_SIGNAL_ACC_EN
    do_reset();
    ylist = 4'b0;
    drive(1'b1, 4'b0001, 1'b0);
    drive(1'b1, 4'b0011, 1'b0);
    drive(1'b1, 4'b0111, 1'b0);
    drive(1'b1, 4'b1000, 1'b0);
    chk("acc.acc_y", acc_y, 1);
    chk("acc.odd_cnt", odd_cnt, 3);
    drive(1'b1, 4'b0010, 1'b1);
    chk("clr_coll.acc_y", acc_y, 1);
    chk("clr_coll.odd_cnt", odd_cnt, 1);
    drive(1'b0, 4'b0000, 1'b1);
    chk("clr_only.acc_y", acc_y, 0);
    chk("clr_only.odd_cnt", odd_cnt, 0);
    for (int i = 0; i < 5; i++) drive(1'b1, 4'b0100, 1'b0);
    chk("sat.odd_cnt2", odd_cnt2, 3);
    chk("sat.odd_cnt", odd_cnt, 5);
`else
    ylist = 4'b0;
`endif

    // Randomized run against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic v, clr;
      logic [3:0] n;
      v   = 1'($urandom_range(0, 3) != 0);
      n   = 4'($urandom);
      clr = 1'($urandom_range(0, 15) == 0);
      drive(v, n, clr);
      chk_model($sformatf("rnd%0d", i));
      chk($sformatf("rnd%0d.inv", i), y, ones_cnt[0]);
    end
    if (ylist != 4'b0) n_fail++;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
